// File: rtl/mult_issue_pkg.sv
// rtl/mult_issue_pkg.sv - shared types and defaults for the multiply issue stage
package mult_issue_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int TIMEOUT_CYCLES_DEF = 32;
   // rstatus index and exception code are shared with the divider issue stage
   localparam int STATUS_REG_DEF     = 30;
   localparam int MULT_EXC_CODE_DEF  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Counter width able to hold 0 .. n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_issue_watchdog_counter.sv
// rtl/mult_issue_watchdog_counter.sv - busy-cycle watchdog with terminal-count flag
module mult_issue_watchdog_counter
   import mult_issue_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam int CW = cnt_width(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   assign terminal = (count == CW'(TIMEOUT_CYCLES - 1));

   // Count enabled cycles from a clear; saturate at the terminal value
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !terminal) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mult_issue.sv
// rtl/mult_issue.sv - issue/retire stage around the Booth multiplier
module mult_issue
   import mult_issue_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int STATUS_REG     = STATUS_REG_DEF,
   parameter int MULT_EXC_CODE  = MULT_EXC_CODE_DEF
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     in_opA,
   input  logic [DATA_WIDTH-1:0]     in_opB,
   input  logic [REG_ADDR_WIDTH-1:0] in_rd,
   output logic [DATA_WIDTH-1:0]     mult_opA,
   output logic [DATA_WIDTH-1:0]     mult_opB,
   output logic                      mult_start,
   input  logic [DATA_WIDTH-1:0]     mult_result,
   input  logic                      mult_exception,
   input  logic                      mult_ready,
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic                      stall
);

   localparam logic [REG_ADDR_WIDTH-1:0] EXC_RD   = REG_ADDR_WIDTH'(STATUS_REG);
   localparam logic [DATA_WIDTH-1:0]     EXC_DATA = DATA_WIDTH'(MULT_EXC_CODE);

   state_t                    state;
   logic [DATA_WIDTH-1:0]     op_a;
   logic [DATA_WIDTH-1:0]     op_b;
   logic [REG_ADDR_WIDTH-1:0] rd_q;
   logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
   logic [DATA_WIDTH-1:0]     wb_data_q;
   logic                      start_q;
   logic                      wb_valid_q;
   logic                      wd_terminal;

   // Watchdog restarts at each START and counts only BUSY cycles
   mult_issue_watchdog_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock    (clock),
      .reset    (reset),
      .clear    (state == ST_START),
      .enable   (state == ST_BUSY),
      .terminal (wd_terminal)
   );

   assign in_ready   = (state == ST_IDLE);
   assign stall      = (state != ST_IDLE);
   assign mult_opA   = op_a;
   assign mult_opB   = op_b;
   assign mult_start = start_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;

   // Issue FSM: latch operands, pulse start, wait for result or timeout, hold writeback
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         op_a       <= '0;
         op_b       <= '0;
         rd_q       <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         start_q    <= 1'b0;
         wb_valid_q <= 1'b0;
      end else if (flush) begin
         // Squash whatever is in flight, including a pending writeback
         state      <= ST_IDLE;
         start_q    <= 1'b0;
         wb_valid_q <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_a    <= in_opA;
                  op_b    <= in_opB;
                  rd_q    <= in_rd;
                  start_q <= 1'b1;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               // mult_ready may still be high from the previous op; not looked at here
               state <= ST_BUSY;
            end
            ST_BUSY: begin
               if (mult_ready) begin
                  if (mult_exception) begin
                     wb_rd_q    <= EXC_RD;
                     wb_data_q  <= EXC_DATA;
                     wb_valid_q <= 1'b1;
                     state      <= ST_DONE;
                  end else if (rd_q == '0) begin
                     // Writes to r0 are discarded, so skip the writeback entirely
                     state <= ST_IDLE;
                  end else begin
                     wb_rd_q    <= rd_q;
                     wb_data_q  <= mult_result;
                     wb_valid_q <= 1'b1;
                     state      <= ST_DONE;
                  end
               end else if (wd_terminal) begin
                  wb_rd_q    <= EXC_RD;
                  wb_data_q  <= EXC_DATA;
                  wb_valid_q <= 1'b1;
                  state      <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (wb_ready) begin
                  wb_valid_q <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_issue.sv
// tb/tb_mult_issue.sv - randomized self-checking bench for mult_issue
module tb_mult_issue;

   localparam int TIMEOUT = 32;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_opA;
   logic [31:0] in_opB;
   logic [4:0]  in_rd;
   logic [31:0] mult_opA;
   logic [31:0] mult_opB;
   logic        mult_start;
   logic [31:0] mult_result;
   logic        mult_exception;
   logic        mult_ready;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;

   int n_cmp = 0;
   int n_bad = 0;

   mult_issue dut (
      .clock          (clock),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_opA         (in_opA),
      .in_opB         (in_opB),
      .in_rd          (in_rd),
      .mult_opA       (mult_opA),
      .mult_opB       (mult_opB),
      .mult_start     (mult_start),
      .mult_result    (mult_result),
      .mult_exception (mult_exception),
      .mult_ready     (mult_ready),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .stall          (stall)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One MULT op. lat: BUSY cycle (0-based) in which the multiplier raises ready,
   // beyond the timeout means never. flush_busy: BUSY cycle carrying flush, -1 none.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input int lat, input int wb_delay, input int flush_busy,
                         input bit flush_done, input bit stale_ready);
      longint      p;
      logic [31:0] prod;
      bit          ovf;
      bit          exc;
      bit          flushed;
      logic [4:0]  erd;
      logic [31:0] edata;
      p    = longint'($signed(a)) * longint'($signed(b));
      prod = p[31:0];
      ovf  = (p != longint'($signed(prod)));
      exc  = (lat > TIMEOUT - 1) ? 1'b1 : ovf;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_stall", stall, 0);
      in_valid = 1'b1; in_opA = a; in_opB = b; in_rd = rd;
      @(negedge clock);
      in_valid = 1'b0; in_opA = $urandom; in_opB = $urandom; in_rd = 5'($urandom);
      chk("start_pulse", mult_start, 1);
      chk("start_stall", stall, 1);
      chk("start_in_ready", in_ready, 0);
      chk("start_opA", mult_opA, a);
      chk("start_opB", mult_opB, b);
      mult_ready = stale_ready; mult_exception = 1'b1; mult_result = 32'hDEADBEEF;
      @(negedge clock);
      flushed = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
         chk("busy_no_start", mult_start, 0);
         chk("busy_no_wb", wb_valid, 0);
         chk("busy_stall", stall, 1);
         mult_ready = (i == lat); mult_exception = ovf; mult_result = prod;
         flush = (i == flush_busy);
         @(negedge clock);
         mult_ready = 1'b0; flush = 1'b0;
         mult_result = $urandom; mult_exception = 1'($urandom);
         if (i == flush_busy) begin flushed = 1'b1; break; end
         if (i == lat) break;
      end
      if (flushed) begin
         chk("flush_busy_idle", in_ready, 1);
         chk("flush_busy_no_wb", wb_valid, 0);
         return;
      end
      if (!exc && rd == 5'd0) begin
         chk("rd0_no_wb", wb_valid, 0);
         chk("rd0_idle", in_ready, 1);
         return;
      end
      erd   = exc ? 5'd30 : rd;
      edata = exc ? 32'd4 : prod;
      chk("wb_valid", wb_valid, 1);
      chk("wb_rd", 32'(wb_rd), 32'(erd));
      chk("wb_data", wb_data, edata);
      chk("done_in_ready", in_ready, 0);
      chk("done_stall", stall, 1);
      for (int k = 0; k < wb_delay; k++) begin
         wb_ready = 1'b0;
         @(negedge clock);
         chk("hold_wb_valid", wb_valid, 1);
         chk("hold_wb_rd", 32'(wb_rd), 32'(erd));
         chk("hold_wb_data", wb_data, edata);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_opA", mult_opA, a);
      end
      wb_ready = 1'b1; flush = flush_done;
      @(negedge clock);
      wb_ready = 1'b0; flush = 1'b0;
      chk("retire_wb_valid", wb_valid, 0);
      chk("retire_in_ready", in_ready, 1);
      chk("retire_stall", stall, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int          fb;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_opA = '0; in_opB = '0; in_rd = '0;
      mult_result = '0; mult_exception = 1'b0; mult_ready = 1'b0; wb_ready = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stall", stall, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_start", mult_start, 0);
      chk("rst_wb_data", wb_data, 0);
      reset = 1'b1;
      @(negedge clock);

      run_op(32'd6, 32'hFFFFFFF9, 5'd5, 16, 0, -1, 0, 0);
      run_op(32'h7FFFFFFF, 32'd2, 5'd9, 16, 0, -1, 0, 1);
      run_op(32'd100, 32'd200, 5'd3, 16, 10, -1, 0, 0);
      run_op(32'd11, 32'd13, 5'd4, 16, 0, 5, 0, 0);
      run_op(32'd3, 32'd4, 5'd7, 16, 0, -1, 0, 0);

      // Asynchronous reset in the middle of a multiply
      in_valid = 1'b1; in_opA = 32'h1234; in_opB = 32'h55; in_rd = 5'd12;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      chk("busy_before_reset", stall, 1);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_stall", stall, 0);
      chk("async_rst_in_ready", in_ready, 1);
      chk("async_rst_opA", mult_opA, 0);
      chk("async_rst_opB", mult_opB, 0);
      chk("async_rst_wb_valid", wb_valid, 0);
      chk("async_rst_wb_rd", 32'(wb_rd), 0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      run_op(32'hFFFFFFFE, 32'hFFFFFFFD, 5'd2, 7, 1, -1, 0, 0);

      run_op(32'd5, 32'd9, 5'd0, 16, 0, -1, 0, 0);
      run_op(32'd5, 32'd9, 5'd9, 1000, 2, -1, 0, 0);
      run_op(32'd5, 32'd9, 5'd0, 1000, 0, -1, 0, 0);
      run_op(32'd8, 32'd8, 5'd1, 31, 0, -1, 0, 0);
      run_op(32'd8, 32'd8, 5'd1, 0, 0, -1, 1, 1);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            a = 32'($signed(16'($urandom)));
            b = 32'($signed(16'($urandom)));
         end else begin
            a = $urandom;
            b = $urandom;
         end
         fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 35)) : -1;
         run_op(a, b, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), fb,
                1'($urandom_range(0, 5) == 0), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
